// File: rtl/sram_like_slave.sv
// rtl/sram_like_slave.sv - sram-like bus responder backed by a 1-cycle synchronous RAM
//
// Accepts requests with addr_ok and returns one in-order data_ok per accepted
// request. The RAM is accessed in the accept cycle. Each response waits in a
// small circular queue until its RAM data is available and its delay timer has
// expired.
//
// Optional feature macro: SRAM_LIKE_RANDOM_STALL_EN
//   When defined, an LFSR randomly withholds addr_ok and delays data_ok.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req, wr, size       request valid, write flag, access size (size is unused)
//   wstrb, addr, wdata  byte enables, byte address, write data
//   addr_ok             request accepted this cycle (req && addr_ok)
//   data_ok, rdata      response valid, read data (0 for writes and when idle)
//   ram_en, ram_wen     RAM enable, RAM byte write enables
//   ram_addr, ram_wdata RAM word address, RAM write data
//   ram_rdata           RAM read data, valid the cycle after a read
module sram_like_slave #(
  parameter int DEPTH  = 2,
  parameter int DELAY  = 0,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [1:0] LAST_C  = 2'(DEPTH - 1);
  localparam logic [2:0] DELAY_C = 3'(DELAY);

  // Queue storage is always four slots. Only the first DEPTH slots are ever
  // used, which keeps every pointer index exactly two bits wide.
  logic [2:0]  count_q, count_d;
  logic [1:0]  head_q, head_d;
  logic [1:0]  tail_q, tail_d;
  logic [3:0]  is_wr_q, is_wr_d;
  logic [3:0]  has_data_q, has_data_d;
  logic [31:0] data_q [4];
  logic [31:0] data_d [4];
  logic [2:0]  timer_q [4];
  logic [2:0]  timer_d [4];
  // An entry pushed last cycle is waiting for its RAM data. That data is on
  // ram_rdata right now.
  logic        pend_q, pend_d;
  logic [1:0]  pend_idx_q, pend_idx_d;

  logic        stall;
  logic        hold;
  logic        accept;
  logic        head_bypass;
  logic        head_ready;
  logic [31:0] head_data;
  logic        unused_ok;

  assign unused_ok = ^{size, addr};

`ifdef SRAM_LIKE_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR with taps 16,14,13,11, shifting toward bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = lfsr_q[0] & lfsr_q[1];
  assign hold  = lfsr_q[2] & lfsr_q[3];
`else
  assign stall = 1'b0;
  assign hold  = 1'b0;
`endif

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LAST_C) ? 2'd0 : p + 2'd1;
  endfunction

  // addr_ok depends only on the occupancy count. A return in the same cycle
  // therefore cannot open a slot for an accept in that cycle.
  assign addr_ok = !reset && (count_q < DEPTH_C) && !stall;
  assign accept  = req && addr_ok;

  assign ram_en    = accept;
  assign ram_wen   = (accept && wr) ? wstrb : 4'b0000;
  assign ram_addr  = addr[ADDR_W+1:2];
  assign ram_wdata = wdata;

  // The head entry may have been pushed last cycle. Its data has not been
  // captured yet, so it is taken straight from ram_rdata.
  assign head_bypass = pend_q && (pend_idx_q == head_q);
  assign head_ready  = (count_q != 3'd0)
                    && (has_data_q[head_q] || head_bypass)
                    && (timer_q[head_q] == 3'd0)
                    && !hold;
  assign head_data   = has_data_q[head_q] ? data_q[head_q]
                     : (is_wr_q[head_q] ? 32'h0 : ram_rdata);

  assign data_ok = !reset && head_ready;
  assign rdata   = data_ok ? head_data : 32'h0;

  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    is_wr_d    = is_wr_q;
    has_data_d = has_data_q;
    for (int i = 0; i < 4; i++) begin
      data_d[i]  = data_q[i];
      timer_d[i] = timer_q[i];
    end
    pend_d     = accept;
    pend_idx_d = tail_q;

    for (int i = 0; i < 4; i++) begin
      if (timer_q[i] != 3'd0) begin
        timer_d[i] = timer_q[i] - 3'd1;
      end
    end

    if (pend_q) begin
      has_data_d[pend_idx_q] = 1'b1;
      data_d[pend_idx_q]     = is_wr_q[pend_idx_q] ? 32'h0 : ram_rdata;
    end

    if (data_ok) begin
      head_d = next_ptr(head_q);
    end

    // A push targets a different slot than the capture above, except when
    // DEPTH is 1. In that case no accept can happen while an entry is pending.
    if (accept) begin
      is_wr_d[tail_q]    = wr;
      has_data_d[tail_q] = 1'b0;
      data_d[tail_q]     = 32'h0;
      timer_d[tail_q]    = DELAY_C;
      tail_d             = next_ptr(tail_q);
    end

    count_d = count_q + {2'b00, accept} - {2'b00, data_ok};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= 3'd0;
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      is_wr_q    <= 4'b0;
      has_data_q <= 4'b0;
      pend_q     <= 1'b0;
      pend_idx_q <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        data_q[i]  <= 32'h0;
        timer_q[i] <= 3'd0;
      end
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      is_wr_q    <= is_wr_d;
      has_data_q <= has_data_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i]  <= data_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

endmodule

// File: doc/sram_like_slave.md
Name: sram_like_slave

Overview:
- Responder end of the sram-like bus: accepts requests from an initiator (IF-stage or MEM-stage master) with addr_ok and returns results with data_ok, strictly in order.
- Backed by a synchronous single-port RAM with 1-cycle read latency.
- Supports up to DEPTH outstanding requests and a configurable extra response delay.
- Serves as the memory-side model/bridge for the fetch and load/store paths.

Parameters:
- DEPTH, 2: maximum accepted-but-unanswered requests (1..4); response queue size.
- DELAY, 0: extra cycles added after RAM latency before data_ok (0..7).
- ADDR_W, 16: RAM word-address width; ram_addr = addr[ADDR_W+1:2].

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  1  request valid from initiator
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word; informational only, wstrb is authoritative
- wstrb  in  4  byte write enables, used when wr = 1
- addr  in  32  byte address
- wdata  in  32  write data
- addr_ok  out  1  request accepted this cycle (handshake = req && addr_ok)
- data_ok  out  1  one response returned this cycle
- rdata  out  32  read data, valid with data_ok; 0 for write responses
- ram_en  out  1  RAM access enable
- ram_wen  out  4  RAM byte write enables
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_wen = 0

Behaviour:
- Reset values: addr_ok = 0, data_ok = 0, rdata = 0, ram_en = 0, ram_wen = 0. Queue emptied, outstanding count = 0, all timers = 0.
- Reset mid-operation discards all pending responses. No data_ok in the reset cycle or for pre-reset requests.
- Accept rule: addr_ok = !reset && count < DEPTH (&& !stall with the optional feature).
  - addr_ok does not depend on req, and does not depend on data_ok in the same cycle.
  - Consequence: when full, a simultaneous return does not permit a same-cycle accept.
- RAM issue: ram_en = req && addr_ok; ram_wen = wr ? wstrb : 0; ram_addr and ram_wdata are driven from addr and wdata combinationally. The RAM access happens in the accept cycle T.
- Queue entry (circular, DEPTH slots; head/tail pointers wrap modulo DEPTH):
  - Fields: is_wr, data[31:0], has_data, timer[2:0].
  - Pushed at T with timer = DELAY, has_data = 0.
  - At T+1 a read entry captures ram_rdata; a write entry just sets has_data with data = 0.
- Timer: decrements by 1 each cycle after T while nonzero (the first decrement occurs at T+1).
- Ready condition: the head is ready when (has_data || head was pushed at T-1) && timer == 0.
  - Earliest data_ok: T+1 when DELAY = 0, where rdata bypasses ram_rdata directly.
  - General case: T+1+DELAY.
- Output: data_ok = head ready; rdata = head data (or the bypass) when data_ok, else 0. At most one data_ok per cycle. Pop on data_ok.
- Count: +1 on accept, −1 on data_ok; both in the same cycle leaves it unchanged. Never exceeds DEPTH and never underflows.
- Response guarantee: every accepted request gets exactly one data_ok, in acceptance order. The initiator has no cancel, so discarded (cancelled) fetches still receive their data_ok.
- Back-to-back:
  - DEPTH ≥ 2, DELAY = 0: sustains one accept and one return per cycle.
  - DEPTH = 1: at most one accept every 2 cycles.
- A write followed by a read of the same address in consecutive cycles returns the new data (RAM write-first ordering is preserved by in-order issue).
- No alignment checking; addr[1:0] is ignored.

Optional Feature:
- Macro: SRAM_LIKE_RANDOM_STALL_EN.
- Enabled:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - stall = lfsr[0] & lfsr[1] forces addr_ok = 0 that cycle.
  - Each queued response additionally holds data_ok low while lfsr[2] & lfsr[3] is 1; ordering and completeness are unchanged.
- Disabled: stall = 0 and no response gating; timing exactly as specified above.

Test Plan:
- Single read, DEPTH=2, DELAY=0, RAM word 0x100 = 0xDEADBEEF:
  - req at cycle 5 with addr 0x400 → addr_ok at 5, ram_en=1 and ram_addr=0x100 at 5.
  - data_ok at 6 with rdata 0xDEADBEEF.
- Streaming: req held high for 4 reads at 0x0, 0x4, 0x8, 0xC → addr_ok every cycle; data_ok on 4 consecutive cycles in order, carrying the RAM contents.
- Full queue, DEPTH=2, DELAY=3:
  - 2 accepts at cycles 0 and 1.
  - addr_ok=0 at cycles 2 through 4.
  - data_ok at 4 and 5; addr_ok=1 again at 5.
- Write then read: write wstrb 4'b0011, wdata 0x12345678 to 0x20 over old 0xFFFFFFFF; next cycle read 0x20.
  - Write response: data_ok with rdata 0.
  - Read response: rdata 0xFFFF5678.
- Reset mid-flight: 2 reads accepted, reset asserted at the cycle before the first data_ok → no data_ok afterwards, addr_ok=1 the cycle after reset deasserts, and the count restarts at 0.
- With SRAM_LIKE_RANDOM_STALL_EN, 1000 random reads/writes against a reference memory model → every accept matched by exactly one in-order data_ok with correct data; addr_ok never high while count == DEPTH.
